pipelined_subtractor: RTL and testbench

- Pipelined 32-bit subtractor with borrow-in: computes diff = a - b - bin and the borrow-out.
- The borrow chain is split into STAGES equal chunks, with one register stage per chunk.
- Uses a valid/ready handshake on both the input and output sides.
- Sits alongside the combinational adder in the datapath. It is the multi-cycle subtract/compare path for ALU and address-compare users.

---
 rtl/pipelined_subtractor.sv | 119 +++++++++++
 tb/tb_pipelined_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor with borrow-in: diff = a - b - bin, plus borrow-out.
// The borrow chain is cut into STAGES equal chunks. Each stage resolves one chunk
// and registers it. The whole pipe advances together under a valid/ready handshake.
// Optional zero/neg/ovf flags are enabled by defining PIPELINED_SUBTRACTOR_FLAGS_EN.
module pipelined_subtractor #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_subtractor: STAGES must be >= 1 and divide WIDTH");
   end

   // Per-stage registers. Operand bits below the current chunk are dead after
   // use. Diff bits above the current chunk are not yet meaningful.
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [STAGES-1:0] br_q;

   logic [WIDTH-1:0]  d_n [STAGES];
   logic [STAGES-1:0] br_n;
   logic              adv;

   // Resolves chunk k of x - y - br. Returns {borrow_out, d with chunk k filled in}.
   function automatic logic [WIDTH:0] chunk_sub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] d,
                                                input logic             br,
                                                input int               k);
      logic [WIDTH-1:0] r;
      logic             c;
      int               j;
      r = d;
      c = br;
      for (int i = 0; i < CW; i++) begin
         j    = k * CW + i;
         r[j] = x[j] ^ y[j] ^ c;
         c    = (~x[j] & y[j]) | (~(x[j] ^ y[j]) & c);
      end
      return {c, r};
   endfunction

   // The pipe only moves when the final stage is empty or being drained.
   assign adv      = ~vld_q[STAGES-1] | out_ready;
   assign in_ready = adv;

   // Chunk arithmetic for every stage. Stage 0 works on the live inputs.
   always_comb begin
      {br_n[0], d_n[0]} = chunk_sub(a, b, '0, bin, 0);
      for (int k = 1; k < STAGES; k++) begin
         {br_n[k], d_n[k]} = chunk_sub(a_q[k-1], b_q[k-1], d_q[k-1], br_q[k-1], k);
      end
   end

   // Stage registers. Everything shifts together on adv, including bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         br_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            d_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q[0] <= in_valid;
         a_q[0]   <= a;
         b_q[0]   <= b;
         d_q[0]   <= d_n[0];
         br_q[0]  <= br_n[0];
         for (int k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            a_q[k]   <= a_q[k-1];
            b_q[k]   <= b_q[k-1];
            d_q[k]   <= d_n[k];
            br_q[k]  <= br_n[k];
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign diff      = d_q[STAGES-1];
   assign bout      = br_q[STAGES-1];

`ifdef PIPELINED_SUBTRACTOR_FLAGS_EN
   // Flags come from the final stage's registered diff and the forwarded operand MSBs.
   // They are gated by out_valid, so they read 0 out of reset and hold through stalls.
   logic a_msb, b_msb;
   assign a_msb = a_q[STAGES-1][WIDTH-1];
   assign b_msb = b_q[STAGES-1][WIDTH-1];
   assign zero  = out_valid & ~|diff;
   assign neg   = out_valid & diff[WIDTH-1];
   assign ovf   = out_valid & (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb);
`else
   assign zero = 1'b0;
   assign neg  = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Randomized and directed bench for pipelined_subtractor with a queue-based reference model.
module tb_pipelined_subtractor;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout, zero, neg, ovf;

   pipelined_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             bin;
   } op_t;

   op_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  n_out    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain wide unsigned arithmetic.
   task automatic compare_result(input op_t op);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] d;
      logic             ez, en, eo;
      full = {1'b0, op.a} - {1'b0, op.b} - {{WIDTH{1'b0}}, op.bin};
      d    = full[WIDTH-1:0];
`ifdef PIPELINED_SUBTRACTOR_FLAGS_EN
      ez = (d == 0);
      en = d[WIDTH-1];
      eo = (op.a[WIDTH-1] != op.b[WIDTH-1]) && (d[WIDTH-1] != op.a[WIDTH-1]);
`else
      ez = 1'b0;
      en = 1'b0;
      eo = 1'b0;
`endif
      check("diff", diff, d);
      check("bout", bout, full[WIDTH]);
      check("zero", zero, ez);
      check("neg",  neg,  en);
      check("ovf",  ovf,  eo);
   endtask

   // Monitor: sampled on the falling edge, where handshakes are stable for the next rising edge.
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_diff;
   logic [2:0]       prev_flags;
   logic             prev_bout;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("in_ready_rule", in_ready, !out_valid || out_ready);
         if (prev_stall && out_valid) begin
            check("stall_diff",  diff, prev_diff);
            check("stall_bout",  bout, prev_bout);
            check("stall_flags", {zero, neg, ovf}, prev_flags);
         end
         prev_stall = out_valid && !out_ready;
         prev_diff  = diff;
         prev_bout  = bout;
         prev_flags = {zero, neg, ovf};
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else compare_result(exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back('{a: a, b: b, bin: bin});
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Presents one operand set and holds it until it is accepted; returns just after that edge.
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic bi, input bit must_be_immediate);
      bit ok = 0;
      a = x; b = y; bin = bi; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (must_be_immediate && i == 0) check("stream_in_ready", in_ready, 1);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check("drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      bit seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready, 1);
      check("rst_diff",      diff, 0);
      check("rst_flags",     {bout, zero, neg, ovf}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First result and its latency.
      send(32'd100, 32'd58, 1'b0, 0);
      lat  = 1;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
         lat++;
      end
      check("first_seen", seen, 1);
      check("latency", lat, STAGES);
      drain();

      // Boundary cases.
      send(32'd0,          32'd1,          1'b0, 0);
      send(32'h8000_0000,  32'd1,          1'b0, 0);
      send(32'h1234_5678,  32'h1234_5678,  1'b0, 0);
      send(32'd0,          32'hFFFF_FFFF,  1'b1, 0);
      send(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 0);
      drain();

      // Back-to-back random stream.
      n_out = 0;
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1);
      drain();
      check("stream_count", n_out, 8);

      // Fill the pipe while the consumer stalls, hold, then release.
      out_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready",  in_ready, 0);
         check("stall_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n_out = 0;
      drain();
      check("stall_count", n_out, STAGES);

      // Random stream with a randomly stalling consumer.
      n_out = 0;
      fork
         for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
         for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
         end
      join
      out_ready = 1'b1;
      drain();
      check("random_count", n_out, 20);

      // Reset with three operands in flight.
      send(32'd9, 32'd3, 1'b0, 1);
      send(32'd8, 32'd2, 1'b1, 1);
      send(32'd7, 32'd1, 1'b0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_diff",      diff, 0);
      check("midrst_flags",     {bout, zero, neg, ovf}, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      n_out = 0;
      repeat (12) @(negedge clk);
      check("no_stale", n_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
